// File: rtl/fifo_buf.sv
// Circular-buffer FIFO with valid/ready on both ports, occupancy count and
// synchronous flush. Pointers carry an extra wrap bit to tell full from empty.
module fifo_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_aL,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_data,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [PTR_WIDTH:0]            head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0][WIDTH-1:0]   entries_q;
  logic                          full, empty, enq_fire, deq_fire;

  // Status comes only from registered pointers, so ready/valid never depend
  // combinationally on the handshake inputs.
  assign empty     = (head_q == tail_q);
  assign full      = (head_q[PTR_WIDTH-1:0] == tail_q[PTR_WIDTH-1:0]) &&
                     (head_q[PTR_WIDTH] != tail_q[PTR_WIDTH]);
  assign count     = tail_q - head_q;
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  assign deq_data  = entries_q[head_q[PTR_WIDTH-1:0]];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + 1'b1;
      if (deq_fire) head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Flush only rewinds pointers; stored data is left as-is.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      entries_q <= '0;
    end else if (enq_fire && !flush) begin
      entries_q[tail_q[PTR_WIDTH-1:0]] <= enq_data;
    end
  end
endmodule

// File: tb/tb_fifo_buf.sv
// Scoreboard bench for fifo_buf: a queue-based model predicts contents at each
// edge; a negedge monitor compares status and dequeued data against it.
module tb_fifo_buf;
  localparam int W = 32;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_aL = 1'b1;
  logic         flush = 1'b0;
  logic         enq_valid = 1'b0;
  logic         deq_ready = 1'b0;
  logic [W-1:0] enq_data = '0;
  logic         enq_ready, deq_valid;
  logic [W-1:0] deq_data;
  logic [3:0]   count;

  int errs = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  bit ef, df;

  fifo_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_aL(rst_aL), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: plain queue of accepted entries.
  always @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) exp_q.delete();
    else if (flush) exp_q.delete();
    else begin
      ef = enq_valid && (exp_q.size() < D);
      df = deq_ready && (exp_q.size() > 0);
      if (df) void'(exp_q.pop_front());
      if (ef) exp_q.push_back(enq_data);
    end
  end

  // Monitor: inputs are stable at negedge, so a handshake seen here is the one
  // that fires at the coming edge.
  always @(negedge clk) begin
    if (rst_aL) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("enq_ready", 32'(enq_ready), 32'(exp_q.size() < D));
      chk("deq_valid", 32'(deq_valid), 32'(exp_q.size() > 0));
      if (deq_valid && deq_ready && exp_q.size() > 0)
        chk("deq_data", deq_data, exp_q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #2 rst_aL = 1'b0;
    #1;
    chk("rst_deq_valid", 32'(deq_valid), 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_deq_data", deq_data, 0);
    #1 rst_aL = 1'b1;
  endtask

  initial begin
    // Reset before any clock edge
    #2 rst_aL = 1'b0;
    #1;
    chk("init_enq_ready", 32'(enq_ready), 1);
    chk("init_deq_valid", 32'(deq_valid), 0);
    chk("init_count", 32'(count), 0);
    chk("init_deq_data", deq_data, 0);
    step();
    rst_aL = 1'b1;

    // Fill and drain
    enq_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      enq_data = 32'(i * 'h11);
      step();
    end
    chk("fill_count", 32'(count), 8);
    chk("fill_enq_ready", 32'(enq_ready), 0);
    enq_data = 32'h99;
    step();
    chk("no_9th_count", 32'(count), 8);
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", deq_data, 32'(i * 'h11));
      step();
    end
    chk("drain_empty", 32'(deq_valid), 0);

    // Streaming
    enq_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_data = 32'(256 + i);
      step();
      chk("stream_count", 32'(count), 1);
      chk("stream_lag", deq_data, 32'(256 + i));
    end
    enq_valid = 1'b0;
    step();
    deq_ready = 1'b0;

    // Full with both sides attempting
    enq_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enq_data = 32'('hA0 + i);
      step();
    end
    enq_data = 32'hEE;
    deq_ready = 1'b1;
    step();
    chk("full_both_count", 32'(count), 7);
    chk("full_both_ready", 32'(enq_ready), 1);
    enq_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    deq_ready = 1'b0;

    // Flush dominance
    enq_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enq_data = 32'('hC0 + i);
      step();
    end
    chk("pre_flush_count", 32'(count), 5);
    flush = 1'b1;
    deq_ready = 1'b1;
    enq_data = 32'hDD;
    step();
    flush = 1'b0;
    deq_ready = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_deq_valid", 32'(deq_valid), 0);
    enq_data = 32'hAB;
    step();
    enq_valid = 1'b0;
    chk("post_flush_count", 32'(count), 1);
    chk("post_flush_data", deq_data, 32'hAB);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("post_flush_empty", 32'(deq_valid), 0);

    // Reset mid-stream
    enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq_data = 32'('hE0 + i);
      step();
    end
    enq_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 3);
    reset_pulse();
    step();
    chk("post_rst_deq_valid", 32'(deq_valid), 0);
    enq_valid = 1'b1;
    enq_data = 32'h5A;
    step();
    enq_valid = 1'b0;
    chk("post_rst_data", deq_data, 32'h5A);
    chk("post_rst_count", 32'(count), 1);

    // Randomized traffic with varying bias, rare flushes and resets
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      enq_valid = ($urandom_range(0, 3) >= bias);
      deq_ready = ($urandom_range(0, 3) >= 2 - bias);
      enq_data  = $urandom;
      flush     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) reset_pulse();
      step();
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
